reg_writeback: RTL and testbench

- Write-side sequencer for the 16x16 register bank.
- Accepts result writes from two producers, the ALU and memory load, through valid/ready handshakes.
- Buffers accepted writes in a small in-order queue and drains them one per cycle onto the bank's write port (rw, dest, dataIn).
- Exports a per-register pending mask so decode logic can stall on read-after-write hazards until the bank holds the new value.

---
 rtl/reg_writeback.sv | 153 +++++++++++++++
 tb/tb_reg_writeback.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Write-side sequencer for the register bank: arbitrates ALU and load results into an
// in-order queue, drains one entry per cycle onto the bank write port, and exports a pending mask.
module reg_writeback #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_dest,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_dest,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     hold,
    output logic                     rw,
    output logic [ADDR_W-1:0]        dest,
    output logic [DATA_W-1:0]        dataIn,
    output logic [(2**ADDR_W)-1:0]   pending,
    output logic [ADDR_W:0]          count,
    output logic                     full,
    output logic                     empty
);

    localparam int                NREG      = 2**ADDR_W;
    localparam int                PTR_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    function automatic logic [NREG-1:0] dec_reg(input logic [ADDR_W-1:0] idx);
        logic [NREG-1:0] onehot;
        onehot      = {NREG{1'b0}};
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

    logic [ADDR_W-1:0] ent_dest_q [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DEPTH-1:0]  ent_vld_q, ent_vld_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              full_s, empty_s, push_s, pop_s;
    logic [ADDR_W-1:0] push_dest_s;
    logic [DATA_W-1:0] push_data_s;

    // Ready is derived from full before any pop, so a full queue never accepts.
    assign full_s    = (count_q == DEPTH_CNT);
    assign empty_s   = (count_q == {(ADDR_W+1){1'b0}});
    assign mem_ready = !full_s;
    assign alu_ready = !full_s && !mem_valid;
    assign pop_s     = !hold && !empty_s;

    // Select the single enqueue of this cycle; memory loads have fixed priority.
    always_comb begin
        push_s      = 1'b0;
        push_dest_s = mem_dest;
        push_data_s = mem_data;
        if (mem_valid && !full_s) begin
            push_s = 1'b1;
        end else if (alu_valid && alu_ready) begin
            push_s      = 1'b1;
            push_dest_s = alu_dest;
            push_data_s = alu_data;
        end else begin
            push_s = 1'b0;
        end
    end

    // Next-state for pointers, occupancy and the registered bank write port.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ent_vld_d = ent_vld_q;
        rw_d      = 1'b0;
        dest_d    = dest_q;
        data_d    = data_q;
        if (push_s) begin
            wr_ptr_d            = wr_ptr_q + PTR_ONE;
            ent_vld_d[wr_ptr_q] = 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d            = rd_ptr_q + PTR_ONE;
            ent_vld_d[rd_ptr_q] = 1'b0;
            rw_d                = 1'b1;
            dest_d              = ent_dest_q[rd_ptr_q];
            data_d              = ent_data_q[rd_ptr_q];
        end else begin
            rw_d = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control and output-port state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            ent_vld_q <= {DEPTH{1'b0}};
            count_q   <= {(ADDR_W+1){1'b0}};
            rw_q      <= 1'b0;
            dest_q    <= {ADDR_W{1'b0}};
            data_q    <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ent_vld_q <= ent_vld_d;
            count_q   <= count_d;
            rw_q      <= rw_d;
            dest_q    <= dest_d;
            data_q    <= data_d;
        end
    end

    // Entry payload storage; contents only matter where the valid bit is set.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            ent_dest_q[wr_ptr_q] <= push_dest_s;
            ent_data_q[wr_ptr_q] <= push_data_s;
        end
    end

    // A register stays pending until the bank write edge has passed.
    always_comb begin
        pending = {NREG{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending | ({NREG{ent_vld_q[i]}} & dec_reg(ent_dest_q[i]));
        end
        pending = pending | ({NREG{rw_q}} & dec_reg(dest_q));
    end

    assign rw     = rw_q;
    assign dest   = dest_q;
    assign dataIn = data_q;
    assign count  = count_q;
    assign full   = full_s;
    assign empty  = empty_s;

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized and directed bench for reg_writeback against a queue-based reference model.
module tb_reg_writeback;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
    localparam int NREG   = 16;

    logic              clk;
    logic              rst;
    logic              alu_valid, mem_valid, hold;
    logic [ADDR_W-1:0] alu_dest, mem_dest;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              alu_ready, mem_ready;
    logic              rw;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] dataIn;
    logic [NREG-1:0]   pending;
    logic [ADDR_W:0]   count;
    logic              full, empty;

    reg_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
        .hold(hold), .rw(rw), .dest(dest), .dataIn(dataIn),
        .pending(pending), .count(count), .full(full), .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [ADDR_W-1:0] d;
        logic [DATA_W-1:0] v;
    } entry_t;

    entry_t            mq[$];
    logic              exp_rw;
    logic [ADDR_W-1:0] exp_dest;
    logic [DATA_W-1:0] exp_data;
    logic              alu_acc, mem_acc;
    int                n_checks = 0;
    int                n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every DUT output with the model's view of the current cycle.
    task automatic check_all();
        logic [NREG-1:0] pm;
        bit              fm;
        fm = (mq.size() == DEPTH);
        pm = '0;
        foreach (mq[i]) pm[mq[i].d] = 1'b1;
        if (exp_rw) pm[exp_dest] = 1'b1;
        check_eq("mem_ready", 32'(mem_ready), 32'(!fm));
        check_eq("alu_ready", 32'(alu_ready), 32'(!fm && !mem_valid));
        check_eq("count",     32'(count),     32'(mq.size()));
        check_eq("full",      32'(full),      32'(fm));
        check_eq("empty",     32'(empty),     32'(mq.size() == 0));
        check_eq("rw",        32'(rw),        32'(exp_rw));
        check_eq("dest",      32'(dest),      32'(exp_dest));
        check_eq("dataIn",    32'(dataIn),    32'(exp_data));
        check_eq("pending",   32'(pending),   32'(pm));
    endtask

    // Reference behaviour at a clock edge: pop the head (if allowed), then append the winner.
    task automatic model_edge();
        bit     fm;
        entry_t e;
        if (rst) begin
            mq.delete();
            exp_rw   = 1'b0;
            exp_dest = '0;
            exp_data = '0;
            alu_acc  = 1'b0;
            mem_acc  = 1'b0;
        end else begin
            fm      = (mq.size() == DEPTH);
            mem_acc = mem_valid && !fm;
            alu_acc = alu_valid && !fm && !mem_valid;
            if (!hold && mq.size() > 0) begin
                e        = mq.pop_front();
                exp_rw   = 1'b1;
                exp_dest = e.d;
                exp_data = e.v;
            end else begin
                exp_rw = 1'b0;
            end
            if (mem_acc) mq.push_back({mem_dest, mem_data});
            else if (alu_acc) mq.push_back({alu_dest, alu_data});
        end
    endtask

    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic alu_set(input logic vld, input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
        alu_valid = vld;
        alu_dest  = d;
        alu_data  = v;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0;
        alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
        mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
        exp_rw = 1'b0; exp_dest = '0; exp_data = '0;
        alu_acc = 1'b0; mem_acc = 1'b0;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // Single ALU write.
        alu_set(1'b1, 4'd3, 16'h1234);
        cycle();
        alu_set(1'b0, 4'd0, 16'h0000);
        repeat (3) cycle();

        // Priority: memory wins, ALU follows next cycle.
        alu_set(1'b1, 4'd5, 16'hAAAA);
        mem_valid = 1'b1; mem_dest = 4'd6; mem_data = 16'hBBBB;
        #1;
        check_eq("prio_alu_ready", 32'(alu_ready), 32'd0);
        check_eq("prio_mem_ready", 32'(mem_ready), 32'd1);
        cycle();
        mem_valid = 1'b0;
        cycle();
        alu_set(1'b0, 4'd0, 16'h0000);
        repeat (3) cycle();

        // Fill under hold, then release.
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            alu_set(1'b1, ADDR_W'(i), DATA_W'(i * 16'h0111));
            cycle();
        end
        alu_set(1'b0, 4'd0, 16'h0000);
        #1;
        check_eq("fill_pending", 32'(pending), 32'h001E);
        check_eq("fill_full",    32'(full),    32'd1);
        hold = 1'b0;
        repeat (6) cycle();

        // Back-to-back pushes wrap the pointers.
        for (int i = 0; i < 10; i++) begin
            alu_set(1'b1, ADDR_W'(i), DATA_W'(i));
            cycle();
        end
        alu_set(1'b0, 4'd0, 16'h0000);
        repeat (3) cycle();

        // Same-register ordering.
        alu_set(1'b1, 4'd7, 16'h0001);
        cycle();
        alu_set(1'b1, 4'd7, 16'h0002);
        cycle();
        alu_set(1'b0, 4'd0, 16'h0000);
        repeat (4) cycle();

        // Reset with entries queued under hold.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_set(1'b1, ADDR_W'(i + 9), DATA_W'(16'hC000 + i));
            cycle();
        end
        alu_set(1'b0, 4'd0, 16'h0000);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check_eq("rst_mid_count",   32'(count),   32'd0);
        check_eq("rst_mid_pending", 32'(pending), 32'd0);
        hold = 1'b0;
        repeat (4) cycle();

        // Random traffic with protocol-respecting producers.
        for (int n = 0; n < 3000; n++) begin
            if (!alu_valid || alu_acc) begin
                alu_valid = ($urandom_range(0, 99) < 55);
                alu_dest  = ADDR_W'($urandom);
                alu_data  = DATA_W'($urandom);
            end
            if (!mem_valid || mem_acc) begin
                mem_valid = ($urandom_range(0, 99) < 35);
                mem_dest  = ADDR_W'($urandom);
                mem_data  = DATA_W'($urandom);
            end
            hold = ($urandom_range(0, 99) < 30);
            rst  = ($urandom_range(0, 199) == 0);
            alu_acc = 1'b0;
            mem_acc = 1'b0;
            cycle();
        end
        rst = 1'b0; hold = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (6) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
